// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/branch control units.
package hazard_pkg;

    typedef enum logic [1:0] {
        BR_IDLE = 2'd0,
        BR_WAIT = 2'd1,
        BR_ERR  = 2'd2
    } br_state_t;

    // Nominal ID->EX->MEM branch resolve latency in cycles.
    localparam int unsigned NOMINAL_RESOLVE = 2;

endpackage

// File: rtl/branch_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/branch_stall_ctrl.sv
// Issue-side branch sequencer: freezes fetch from branch accept in ID until MEM
// resolves it, steers the PC mux, keeps perf counters and a sticky timeout flag.
module branch_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MAX_WAIT  = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 branch_id,
    input  logic                 stall_ext,
    input  logic                 branch_resolved,
    input  logic                 branch_taken,
    output logic                 branchhazard,
    output logic                 bubble_ifid,
    output logic                 pc_src_branch,
    output logic                 busy,
    output logic                 err_timeout,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] taken_cnt,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    localparam int unsigned WCW = $clog2(MAX_WAIT + 1);

    br_state_t      state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           err_q, err_d;
    logic           branch_inc, taken_inc, stall_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BR_IDLE;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        err_d         = err_q;
        branchhazard  = 1'b1;
        bubble_ifid   = 1'b0;
        pc_src_branch = 1'b0;
        branch_inc    = 1'b0;
        taken_inc     = 1'b0;

        unique case (state_q)
            BR_IDLE: begin
                // A branch stalled by load-use is not accepted; that unit owns the stall.
                if (branch_id && !stall_ext) begin
                    branchhazard = 1'b0;
                    bubble_ifid  = 1'b1;
                    branch_inc   = 1'b1;
                    state_d      = BR_WAIT;
                    wait_cnt_d   = WCW'(1);
                end
            end
            BR_WAIT: begin
                if (branch_resolved) begin
                    pc_src_branch = branch_taken;
                    taken_inc     = branch_taken;
                    state_d       = BR_IDLE;
                    wait_cnt_d    = '0;
                end else begin
                    branchhazard = 1'b0;
                    bubble_ifid  = 1'b1;
                    if (wait_cnt_q == WCW'(MAX_WAIT)) begin
                        state_d = BR_ERR;
                        err_d   = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WCW'(1);
                    end
                end
            end
            BR_ERR: begin
                branchhazard = 1'b0;
                bubble_ifid  = 1'b1;
            end
            default: state_d = BR_IDLE;
        endcase

        // Outputs are released for the whole reset cycle, even if state is still WAIT/ERR.
        if (reset) begin
            branchhazard  = 1'b1;
            bubble_ifid   = 1'b0;
            pc_src_branch = 1'b0;
            branch_inc    = 1'b0;
            taken_inc     = 1'b0;
        end
        busy = !reset && (state_q != BR_IDLE);
    end

    assign stall_inc   = !branchhazard;
    assign err_timeout = err_q;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_branch_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (branch_inc),
        .count (branch_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_taken_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (taken_inc),
        .count (taken_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_branch_stall_ctrl.sv
// Randomized bench for branch_stall_ctrl against a cycle-level behavioural model.
module tb_branch_stall_ctrl;

    localparam int unsigned MW   = 4;
    localparam int unsigned CW   = 4;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          branch_id;
    logic          stall_ext;
    logic          branch_resolved;
    logic          branch_taken;
    logic          branchhazard;
    logic          bubble_ifid;
    logic          pc_src_branch;
    logic          busy;
    logic          err_timeout;
    logic [CW-1:0] branch_cnt;
    logic [CW-1:0] taken_cnt;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    branch_stall_ctrl #(.MAX_WAIT(MW), .CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .branch_id       (branch_id),
        .stall_ext       (stall_ext),
        .branch_resolved (branch_resolved),
        .branch_taken    (branch_taken),
        .branchhazard    (branchhazard),
        .bubble_ifid     (bubble_ifid),
        .pc_src_branch   (pc_src_branch),
        .busy            (busy),
        .err_timeout     (err_timeout),
        .branch_cnt      (branch_cnt),
        .taken_cnt       (taken_cnt),
        .stall_cnt       (stall_cnt)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int unsigned sat_inc(input int unsigned v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Model: a branch is either absent, in flight (with count of unresolved cycles), or hung.
    bit          m_inflight, m_hung;
    int unsigned m_unresolved, m_br, m_tk, m_st;
    bit          e_hz, e_bub, e_pc, e_busy;

    initial begin
        reset = 1'b1; branch_id = 1'b0; stall_ext = 1'b0;
        branch_resolved = 1'b0; branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        m_inflight = 0; m_hung = 0; m_unresolved = 0; m_br = 0; m_tk = 0; m_st = 0;

        for (int i = 0; i < 3000; i++) begin
            cyc = i;
            @(posedge clk);
            #1;
            reset           = (i == 0) || ($urandom_range(0, 59) == 0);
            branch_id       = 1'($urandom_range(0, 1));
            stall_ext       = ($urandom_range(0, 9) < 3);
            branch_resolved = ($urandom_range(0, 9) < 3);
            branch_taken    = 1'($urandom_range(0, 1));
            #3;

            if (reset) begin
                e_hz = 1; e_bub = 0; e_pc = 0; e_busy = 0;
            end else if (m_hung) begin
                e_hz = 0; e_bub = 1; e_pc = 0; e_busy = 1;
            end else if (m_inflight) begin
                e_busy = 1;
                e_hz   = branch_resolved;
                e_bub  = !branch_resolved;
                e_pc   = branch_resolved && branch_taken;
            end else begin
                e_busy = 0; e_pc = 0;
                e_hz   = !(branch_id && !stall_ext);
                e_bub  = branch_id && !stall_ext;
            end

            check_eq("branchhazard",  32'(branchhazard),  32'(e_hz));
            check_eq("bubble_ifid",   32'(bubble_ifid),   32'(e_bub));
            check_eq("pc_src_branch", 32'(pc_src_branch), 32'(e_pc));
            check_eq("busy",          32'(busy),          32'(e_busy));
            check_eq("err_timeout",   32'(err_timeout),   32'(m_hung));
            check_eq("branch_cnt",    32'(branch_cnt),    m_br);
            check_eq("taken_cnt",     32'(taken_cnt),     m_tk);
            check_eq("stall_cnt",     32'(stall_cnt),     m_st);

            if (reset) begin
                m_inflight = 0; m_hung = 0; m_unresolved = 0; m_br = 0; m_tk = 0; m_st = 0;
            end else begin
                if (!e_hz) m_st = sat_inc(m_st);
                if (m_hung) begin
                    // stays hung until reset
                end else if (m_inflight) begin
                    if (branch_resolved) begin
                        m_inflight = 0;
                        if (branch_taken) m_tk = sat_inc(m_tk);
                    end else begin
                        m_unresolved++;
                        if (m_unresolved == MW) begin
                            m_hung     = 1;
                            m_inflight = 0;
                        end
                    end
                end else if (branch_id && !stall_ext) begin
                    m_inflight   = 1;
                    m_unresolved = 0;
                    m_br         = sat_inc(m_br);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
